// File: rtl/mem_pkg.sv
// Shared definitions for the MEM/LSU pipeline stage.
//   size_e   : access size encoding carried on in_size (B/H/W/D)
//   state_e  : stage FSM states
//   byte_en  : byte-enable mask for a given size and byte offset (8-lane form)
//   replicate: copies LSB-aligned store data into every lane of its size
//   misaligned: true when a byte offset is not a multiple of the access size
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Written for the widest (64-bit, 8-lane) case; 32-bit users take the low half.
  function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] ofs);
    logic [7:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      SZ_W:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask << ofs;
  endfunction

  function automatic logic [63:0] replicate(input logic [63:0] data, input logic [1:0] size);
    logic [63:0] rep;
    case (size)
      SZ_B:    rep = {8{data[7:0]}};
      SZ_H:    rep = {4{data[15:0]}};
      SZ_W:    rep = {2{data[31:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

  function automatic logic misaligned(input logic [2:0] ofs, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = ofs[0];
      SZ_W:    bad = |ofs[1:0];
      default: bad = |ofs;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner.
//   rdata  : raw DATA_W-wide word returned by data memory
//   ofs    : byte offset of the access inside that word
//   size   : access size (B/H/W/D)
//   uns    : 1 = zero-extend, 0 = sign-extend
//   result : selected bytes shifted down to bit 0 and extended to DATA_W
module lsu_load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OFS_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFS_W-1:0]  ofs,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] lane;
  logic              sign;
  int                nbits;

  // Bits above the access width are filled with the extension bit; a D access
  // (or W on a 32-bit build) simply passes the whole lane through.
  always_comb begin
    lane  = rdata >> {ofs, 3'b000};
    nbits = DATA_W;
    sign  = 1'b0;
    case (size)
      SZ_B: begin
        nbits = 8;
        sign  = lane[7];
      end
      SZ_H: begin
        nbits = 16;
        sign  = lane[15];
      end
      SZ_W: begin
        nbits = 32;
        sign  = lane[31];
      end
      default: begin
        nbits = DATA_W;
        sign  = lane[DATA_W-1];
      end
    endcase
    if (uns) begin
      sign = 1'b0;
    end
    result = '0;
    for (int i = 0; i < DATA_W; i++) begin
      result[i] = (i < nbits) ? lane[i] : sign;
    end
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// MEM pipeline stage between EX and WB.
//   EX side : in_valid/in_ready handshake, instruction fields, flush
//   dmem    : req/gnt request channel (we/addr/be/wdata), rvalid/rdata response
//   WB side : out_valid/out_ready handshake, register write result, exception flag
//   bypass  : fwd_rf_we/fwd_waddr/fwd_data to EX, fwd_pending while a load waits for data
// Holds one instruction at a time. Non-memory ops and exceptions complete the
// cycle after capture; loads and stores go through the memory request FSM.
module mem_lsu_stage
  import mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int OFS_W  = $clog2(DATA_W/8)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_ld,
  input  logic                in_st,
  input  logic [1:0]          in_size,
  input  logic                in_uns,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                in_rf_we,
  input  logic [4:0]          in_rf_waddr,
  input  logic [DATA_W-1:0]   in_ex_res,
  input  logic [63:0]         in_pc,
  input  logic [31:0]         in_inst,
  input  logic                flush,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W/8-1:0] dmem_be,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_rf_we,
  output logic [4:0]          out_rf_waddr,
  output logic [DATA_W-1:0]   out_rf_wdata,
  output logic [63:0]         out_pc,
  output logic [31:0]         out_inst,
  output logic                out_exc,
  output logic                fwd_rf_we,
  output logic [4:0]          fwd_waddr,
  output logic [DATA_W-1:0]   fwd_data,
  output logic                fwd_pending
);

  localparam int BE_W = DATA_W/8;

  state_e              state_q, state_d;
  logic                kill_q, kill_d;
  logic                ld_q, ld_d;
  logic                st_q, st_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rf_we_q, rf_we_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [DATA_W-1:0]   ex_res_q, ex_res_d;
  logic [63:0]         pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic                exc_q, exc_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                capture;
  logic                in_exc;
  logic [7:0]          be_full;
  logic [63:0]         rep_full;
  logic [DATA_W-1:0]   ld_result;
  logic [DATA_W-1:0]   result_data;

  // A flush in the same cycle blocks capture of the incoming instruction.
  assign capture = in_valid & in_ready & ~flush;

  // D accesses do not exist on a 32-bit build and are reported like misalignment.
  assign in_exc = (in_ld | in_st) &
                  (misaligned(3'(in_addr[OFS_W-1:0]), in_size) |
                   ((in_size == SZ_D) && (DATA_W == 32)));

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    ld_d     = ld_q;
    st_d     = st_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rf_we_d  = rf_we_q;
    waddr_d  = waddr_q;
    ex_res_d = ex_res_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    exc_d    = exc_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      // A granted store has already been performed by memory, so a flush can
      // only suppress its commit. A granted load still owes us an rvalid, which
      // must be swallowed before the stage is reused.
      ST_REQ: begin
        if (dmem_gnt) begin
          if (st_q) begin
            state_d = flush ? ST_IDLE : ST_DONE;
          end else begin
            state_d = ST_WAIT;
            kill_d  = flush;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          if (kill_q || flush) begin
            state_d = ST_IDLE;
            kill_d  = 1'b0;
          end else begin
            rdata_d = dmem_rdata;
            state_d = ST_DONE;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (flush || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Capture overrides the drain-to-IDLE above, giving back-to-back issue from DONE.
    if (capture) begin
      ld_d     = in_ld;
      st_d     = in_st;
      size_d   = in_size;
      uns_d    = in_uns;
      addr_d   = in_addr;
      wdata_d  = in_wdata;
      rf_we_d  = in_rf_we;
      waddr_d  = in_rf_waddr;
      ex_res_d = in_ex_res;
      pc_d     = in_pc;
      inst_d   = in_inst;
      exc_d    = in_exc;
      kill_d   = 1'b0;
      state_d  = (in_exc || !(in_ld || in_st)) ? ST_DONE : ST_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      kill_q   <= 1'b0;
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rf_we_q  <= 1'b0;
      waddr_q  <= 5'd0;
      ex_res_q <= '0;
      pc_q     <= 64'd0;
      inst_q   <= 32'd0;
      exc_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      ld_q     <= ld_d;
      st_q     <= st_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rf_we_q  <= rf_we_d;
      waddr_q  <= waddr_d;
      ex_res_q <= ex_res_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      exc_q    <= exc_d;
      rdata_q  <= rdata_d;
    end
  end

  lsu_load_align #(
    .DATA_W (DATA_W),
    .OFS_W  (OFS_W)
  ) u_align (
    .rdata  (rdata_q),
    .ofs    (addr_q[OFS_W-1:0]),
    .size   (size_q),
    .uns    (uns_q),
    .result (ld_result)
  );

  // Request fields come straight from the entry register, so they cannot move
  // while the request waits for gnt.
  always_comb begin
    be_full     = byte_en(size_q, 3'(addr_q[OFS_W-1:0]));
    rep_full    = replicate(64'(wdata_q), size_q);
    result_data = ld_q ? ld_result : ex_res_q;

    in_ready    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);

    dmem_req    = (state_q == ST_REQ);
    dmem_we     = dmem_req & st_q;
    dmem_addr   = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    dmem_be     = dmem_req ? be_full[BE_W-1:0] : '0;
    dmem_wdata  = rep_full[DATA_W-1:0];

    out_valid    = (state_q == ST_DONE) & ~flush;
    out_rf_we    = out_valid & rf_we_q & ~exc_q;
    out_exc      = out_valid & exc_q;
    out_rf_waddr = waddr_q;
    out_rf_wdata = result_data;
    out_pc       = pc_q;
    out_inst     = inst_q;

    // A killed load will never write, so it must not be forwarded or stall EX.
    fwd_rf_we   = (state_q != ST_IDLE) & rf_we_q & ~exc_q & ~kill_q;
    fwd_waddr   = waddr_q;
    fwd_data    = result_data;
    fwd_pending = ld_q & ~exc_q & ~kill_q &
                  ((state_q == ST_REQ) | (state_q == ST_WAIT));
  end

endmodule

// File: tb/tb_mem_lsu_stage.sv
module tb_mem_lsu_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_ld;
  logic        in_st;
  logic [1:0]  in_size;
  logic        in_uns;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        in_rf_we;
  logic [4:0]  in_rf_waddr;
  logic [63:0] in_ex_res;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        flush;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic        out_rf_we;
  logic [4:0]  out_rf_waddr;
  logic [63:0] out_rf_wdata;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_exc;
  logic        fwd_rf_we;
  logic [4:0]  fwd_waddr;
  logic [63:0] fwd_data;
  logic        fwd_pending;

  mem_lsu_stage #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld), .in_st(in_st),
    .in_size(in_size), .in_uns(in_uns), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_ex_res(in_ex_res),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rf_we(out_rf_we),
    .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata), .out_pc(out_pc),
    .out_inst(out_inst), .out_exc(out_exc),
    .fwd_rf_we(fwd_rf_we), .fwd_waddr(fwd_waddr), .fwd_data(fwd_data),
    .fwd_pending(fwd_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rfWe;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        checkData;
    logic        exc;
    logic [63:0] pc;
    logic [31:0] inst;
  } expOut_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        checkData;
  } expReq_t;

  expOut_t outQ[$];
  expReq_t reqQ[$];
  expOut_t cmpOut;
  expReq_t cmpReq;

  // Memory responder knobs
  int          gntDelay  = 0;
  int          rvDelay   = 1;
  logic [63:0] memRdata  = 64'd0;
  int          reqCycles = 0;
  bit          strayRv   = 1'b0;
  int          waitCnt   = 0;
  int          rvCnt     = 0;
  logic [63:0] pcCounter = 64'h8000_0000;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Load result from the architectural rule: pick the bytes, then extend.
  function automatic logic [63:0] modelLoad(input logic [63:0] rd, input int size,
                                            input int ofs, input bit uns);
    int          nb;
    logic [63:0] v;
    logic [63:0] mask;
    nb   = 1 << size;
    v    = rd >> (8 * ofs);
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic expReq_t modelReq(input bit st, input int size,
                                       input logic [63:0] addr, input logic [63:0] wd);
    expReq_t r;
    int      nb;
    int      ofs;
    nb  = 1 << size;
    ofs = int'(addr % 8);
    r.we   = st;
    r.addr = addr - (addr % 8);
    r.be   = 8'h00;
    r.wdata = 64'd0;
    r.checkData = st;
    for (int b = 0; b < 8; b++) begin
      r.be[b] = (b >= ofs) && (b < ofs + nb);
      r.wdata[8*b +: 8] = wd[8*(b % nb) +: 8];
    end
    return r;
  endfunction

  // Simple memory: grants after gntDelay cycles of request, answers loads rvDelay cycles after gnt.
  initial begin
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 64'd0;
    forever begin
      @(posedge clk);
      #2;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (rvCnt > 0) begin
        rvCnt--;
        if (rvCnt == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = memRdata;
        end
      end
      if (strayRv) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        strayRv     = 1'b0;
      end
      if (dmem_req) begin
        reqCycles++;
        if (waitCnt >= gntDelay) begin
          dmem_gnt = 1'b1;
          waitCnt  = 0;
          if (!dmem_we) rvCnt = rvDelay;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Compare process: every committed result and every request cycle against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (outQ.size() == 0) begin
          checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          cmpOut = outQ.pop_front();
          checkOutput("out_rf_we", 64'(out_rf_we), 64'(cmpOut.rfWe));
          checkOutput("out_rf_waddr", 64'(out_rf_waddr), 64'(cmpOut.waddr));
          checkOutput("out_exc", 64'(out_exc), 64'(cmpOut.exc));
          checkOutput("out_pc", out_pc, cmpOut.pc);
          checkOutput("out_inst", 64'(out_inst), 64'(cmpOut.inst));
          if (cmpOut.checkData) checkOutput("out_rf_wdata", out_rf_wdata, cmpOut.wdata);
        end
      end
      if (dmem_req) begin
        if (reqQ.size() == 0) begin
          checkOutput("unexpected_dmem_req", 64'(dmem_req), 64'd0);
        end else begin
          cmpReq = reqQ[0];
          checkOutput("dmem_we", 64'(dmem_we), 64'(cmpReq.we));
          checkOutput("dmem_addr", dmem_addr, cmpReq.addr);
          checkOutput("dmem_be", 64'(dmem_be), 64'(cmpReq.be));
          if (cmpReq.checkData) checkOutput("dmem_wdata", dmem_wdata, cmpReq.wdata);
          if (dmem_gnt) void'(reqQ.pop_front());
        end
      end
    end
  end

  // Presents one instruction and returns just after the edge that captured it.
  task automatic applyStimulus(input bit ld, input bit st, input int size, input bit uns,
                               input logic [63:0] addr, input logic [63:0] wd,
                               input bit rfWe, input logic [4:0] waddr,
                               input logic [63:0] exRes, input logic [63:0] rd,
                               input bit expectOut);
    expOut_t e;
    bit      exc;
    bit      rdy;
    int      nb;
    nb  = 1 << size;
    exc = (ld || st) && ((addr % nb) != 0);
    in_valid    = 1'b1;
    in_ld       = ld;
    in_st       = st;
    in_size     = 2'(size);
    in_uns      = uns;
    in_addr     = addr;
    in_wdata    = wd;
    in_rf_we    = rfWe;
    in_rf_waddr = waddr;
    in_ex_res   = exRes;
    in_pc       = pcCounter;
    in_inst     = pcCounter[31:0] ^ 32'h0000_0013;
    e.rfWe      = rfWe && !exc;
    e.waddr     = waddr;
    e.wdata     = ld ? modelLoad(rd, size, int'(addr % 8), uns) : exRes;
    e.checkData = !exc;
    e.exc       = exc;
    e.pc        = pcCounter;
    e.inst      = pcCounter[31:0] ^ 32'h0000_0013;
    if (expectOut) outQ.push_back(e);
    if ((ld || st) && !exc) reqQ.push_back(modelReq(st, size, addr, wd));
    pcCounter = pcCounter + 64'd4;
    rdy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
    end
    if (!rdy) checkOutput("capture_timeout", 64'd0, 64'd1);
    #2;
    if (ld) memRdata = rd;
  endtask

  task automatic idleInputs();
    in_valid = 1'b0;
    in_ld    = 1'b0;
    in_st    = 1'b0;
  endtask

  task automatic waitOut(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  int t0;
  int r0;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0; in_size = 2'd0; in_uns = 1'b0;
    in_addr = 64'd0; in_wdata = 64'd0; in_rf_we = 1'b0; in_rf_waddr = 5'd0;
    in_ex_res = 64'd0; in_pc = 64'd0; in_inst = 32'd0; flush = 1'b0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_dmem_req", 64'(dmem_req), 64'd0);
    checkOutput("rst_dmem_be", 64'(dmem_be), 64'd0);
    checkOutput("rst_fwd_rf_we", 64'(fwd_rf_we), 64'd0);
    checkOutput("rst_fwd_pending", 64'(fwd_pending), 64'd0);
    checkOutput("rst_out_rf_wdata", out_rf_wdata, 64'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] ALU single op and throughput");
    applyStimulus(0, 0, 0, 0, 64'd0, 64'd0, 1, 5'd5, 64'h1234, 64'd0, 1);
    idleInputs();
    @(negedge clk);
    checkOutput("alu_out_valid", 64'(out_valid), 64'd1);
    checkOutput("alu_wdata", out_rf_wdata, 64'h1234);
    nextCycle();
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 0, 64'd0, 64'd0, 1, 5'(k + 1), 64'hA000 + 64'(k), 64'd0, 1);
    end
    checkOutput("alu_throughput_cycles", 64'(cyc - t0), 64'd4);
    idleInputs();
    @(negedge clk);
    nextCycle();

    $display("[TB] LB sign-extended from byte 7");
    gntDelay = 0; rvDelay = 3;
    applyStimulus(1, 0, 0, 0, 64'h1000_0007, 64'd0, 1, 5'd7, 64'hDEAD,
                  64'h80AA_BBCC_DDEE_FF11, 1);
    idleInputs();
    @(negedge clk);
    checkOutput("lb_fwd_pending", 64'(fwd_pending), 64'd1);
    waitOut("lb", 20);
    checkOutput("lb_wdata", out_rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    nextCycle();

    $display("[TB] SH lane replication");
    gntDelay = 2;
    applyStimulus(0, 1, 1, 0, 64'h2000_0002, 64'hBEEF, 0, 5'd0, 64'h0, 64'd0, 1);
    idleInputs();
    @(negedge clk);
    checkOutput("sh_be", 64'(dmem_be), 64'h0C);
    checkOutput("sh_wdata", dmem_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    checkOutput("sh_addr", dmem_addr, 64'h2000_0000);
    waitOut("sh", 20);
    nextCycle();

    $display("[TB] LW misaligned");
    r0 = reqCycles;
    applyStimulus(1, 0, 2, 0, 64'h3000_0002, 64'd0, 1, 5'd9, 64'h55, 64'd0, 1);
    idleInputs();
    waitOut("lw_exc", 5);
    checkOutput("lw_exc_flag", 64'(out_exc), 64'd1);
    checkOutput("lw_exc_rf_we", 64'(out_rf_we), 64'd0);
    nextCycle();
    nextCycle();
    checkOutput("lw_exc_no_req", 64'(reqCycles - r0), 64'd0);

    $display("[TB] flush while waiting for load data");
    gntDelay = 0; rvDelay = 3;
    applyStimulus(1, 0, 3, 0, 64'h4000_0000, 64'd0, 1, 5'd3, 64'd0, 64'h1111_2222_3333_4444, 0);
    idleInputs();
    nextCycle();
    flush = 1'b1;
    nextCycle();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_wait_pending", 64'(fwd_pending), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("flush_wait_no_out", 64'(out_valid), 64'd0);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 64'd0, 64'd0, 1, 5'd4, 64'h77, 64'd0, 1);
    idleInputs();
    waitOut("after_flush", 5);
    checkOutput("after_flush_wdata", out_rf_wdata, 64'h77);
    nextCycle();

    $display("[TB] flush while request waits for grant");
    gntDelay = 10;
    applyStimulus(1, 0, 2, 0, 64'h5000_0004, 64'd0, 1, 5'd6, 64'd0, 64'd0, 0);
    idleInputs();
    nextCycle();
    flush = 1'b1;
    nextCycle();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_req_dropped", 64'(dmem_req), 64'd0);
    checkOutput("flush_req_in_ready", 64'(in_ready), 64'd1);
    reqQ.delete();
    nextCycle();

    $display("[TB] stray rvalid in idle");
    strayRv = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("stray_no_out", 64'(out_valid), 64'd0);
    checkOutput("stray_in_ready", 64'(in_ready), 64'd1);
    nextCycle();

    $display("[TB] WB back-pressure on a held load");
    gntDelay = 1; rvDelay = 1;
    out_ready = 1'b0;
    applyStimulus(1, 0, 1, 0, 64'h6000_0006, 64'd0, 1, 5'd12, 64'd0,
                  64'h9ABC_0000_0000_0000, 1);
    idleInputs();
    waitOut("stall", 20);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_wdata", out_rf_wdata, 64'hFFFF_FFFF_FFFF_9ABC);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_fwd_pending", 64'(fwd_pending), 64'd0);
      checkOutput("stall_fwd_data", fwd_data, 64'hFFFF_FFFF_FFFF_9ABC);
      checkOutput("stall_fwd_rf_we", 64'(fwd_rf_we), 64'd1);
      @(negedge clk);
    end
    nextCycle();
    out_ready = 1'b1;
    @(negedge clk);
    nextCycle();

    $display("[TB] load/store pattern sweep");
    gntDelay = 1; rvDelay = 2;
    begin
      int lsz[7]  = '{0, 0, 1, 1, 2, 2, 3};
      int lofs[7] = '{1, 3, 4, 6, 4, 0, 0};
      bit luns[7] = '{1, 0, 1, 0, 0, 1, 0};
      int ssz[3]  = '{0, 2, 3};
      int sofs[3] = '{5, 4, 0};
      for (int k = 0; k < 7; k++) begin
        applyStimulus(1, 0, lsz[k], luns[k], 64'h7000_0000 + 64'(lofs[k]), 64'd0, 1,
                      5'(16 + k), 64'd0, 64'hF1E2_D3C4_B5A6_9788, 1);
        idleInputs();
        waitOut("sweep_ld", 20);
        nextCycle();
      end
      for (int k = 0; k < 3; k++) begin
        applyStimulus(0, 1, ssz[k], 0, 64'h7100_0000 + 64'(sofs[k]),
                      64'h0123_4567_89AB_CDEF, 0, 5'd0, 64'h42, 64'd0, 1);
        idleInputs();
        waitOut("sweep_st", 20);
        nextCycle();
      end
    end

    repeat (3) nextCycle();
    checkOutput("outq_drained", 64'(outQ.size()), 64'd0);
    checkOutput("reqq_drained", 64'(reqQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
